// File: rtl/nand_logic.sv
// -----------------------------------------------------------------------------
// nand_logic
//
// Bitwise two-input NAND reference cell. The result is available two ways:
// combinationally on y, and as a registered copy on y_reg with a one-cycle
// out_valid strobe. The cell also keeps sticky coverage flags for the four
// input combinations seen on bit 0, and a saturating count of accepted samples.
//
// Parameters
//   WIDTH      operand/result width, 1..64
//   CNT_W      width of the accepted-sample counter
//
// Ports
//   clk        system clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   a, b       operands
//   in_valid   qualifies a/b for the registered path
//   y          combinational ~(a & b), independent of clk/rst/in_valid
//   y_reg      registered result of the last accepted sample
//   out_valid  high for exactly the cycle after an accepted sample
//   combo_seen sticky flags, bit index = {a[0], b[0]} of accepted samples
//   all_seen   all four combinations have been accepted
//   sample_cnt saturating count of accepted samples
// -----------------------------------------------------------------------------
module nand_logic #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_reg,
  output logic             out_valid,
  output logic [3:0]       combo_seen,
  output logic             all_seen,
  output logic [CNT_W-1:0] sample_cnt
);

  logic [WIDTH-1:0] nand_res;
  logic [1:0]       combo_idx;
  logic [3:0]       combo_next;
  logic [CNT_W-1:0] cnt_next;

  // Shared by the combinational output and the register input so both paths
  // always agree.
  assign nand_res = ~(a & b);
  assign y        = nand_res;

  assign combo_idx = {a[0], b[0]};

  always_comb begin
    // NOTE: every output of a combinational block gets a default first; a path
    // that leaves one unassigned would infer a latch.
    combo_next = combo_seen;
    cnt_next   = sample_cnt;
    combo_next[combo_idx] = 1'b1;
    // Saturate rather than wrap so a long run never reads as "few samples".
    if (sample_cnt != {CNT_W{1'b1}}) begin
      cnt_next = sample_cnt + CNT_W'(1);
    end
  end

  // Reset wins over in_valid: a sample presented with rst high is dropped.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    if (rst) begin
      y_reg      <= {WIDTH{1'b1}};  // NAND of all-zero operands
      out_valid  <= 1'b0;
      combo_seen <= 4'b0000;
      sample_cnt <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y_reg      <= nand_res;
        combo_seen <= combo_next;
        sample_cnt <= cnt_next;
      end
    end
  end

  assign all_seen = &combo_seen;

endmodule

// File: tb/tb_nand_logic.sv
// -----------------------------------------------------------------------------
// tb_nand_logic
//
// Directed bench for nand_logic. Three instances share clk/rst:
//   u1 : WIDTH=1, CNT_W=16  truth table, registered path, coverage, reset
//   u8 : WIDTH=8, CNT_W=16  vector-width behaviour
//   uc : WIDTH=1, CNT_W=2   counter saturation
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_nand_logic;

  logic clk = 1'b0;
  logic rst;

  logic       a1, b1, v1;
  logic       y1, yr1, ov1, as1;
  logic [3:0] cs1;
  logic [15:0] cnt1;

  logic [7:0] a8, b8, y8, yr8;
  logic       v8, ov8, as8;
  logic [3:0] cs8;
  logic [15:0] cnt8;

  logic       ac, bc, vc, yc, yrc, ovc, asc;
  logic [3:0] csc;
  logic [1:0] cntc;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  nand_logic #(.WIDTH(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(v1),
    .y(y1), .y_reg(yr1), .out_valid(ov1), .combo_seen(cs1),
    .all_seen(as1), .sample_cnt(cnt1)
  );

  nand_logic #(.WIDTH(8), .CNT_W(16)) u8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(v8),
    .y(y8), .y_reg(yr8), .out_valid(ov8), .combo_seen(cs8),
    .all_seen(as8), .sample_cnt(cnt8)
  );

  nand_logic #(.WIDTH(1), .CNT_W(2)) uc (
    .clk(clk), .rst(rst), .a(ac), .b(bc), .in_valid(vc),
    .y(yc), .y_reg(yrc), .out_valid(ovc), .combo_seen(csc),
    .all_seen(asc), .sample_cnt(cntc)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a1 = 0; b1 = 0; v1 = 0;
    a8 = 0; b8 = 0; v8 = 0;
    ac = 0; bc = 0; vc = 0;
    tick();
    tick();

    // Reset state
    chk("rst_y_reg1",  64'(yr1),  64'h1);
    chk("rst_ov1",     64'(ov1),  64'h0);
    chk("rst_combo1",  64'(cs1),  64'h0);
    chk("rst_all1",    64'(as1),  64'h0);
    chk("rst_cnt1",    64'(cnt1), 64'h0);
    chk("rst_y_reg8",  64'(yr8),  64'hFF);
    chk("rst_cntc",    64'(cntc), 64'h0);

    // Combinational truth table, applied while rst is high (y ignores it)
    a1 = 0; b1 = 0; #10; chk("tt_00", 64'(y1), 64'h1);
    a1 = 0; b1 = 1; #10; chk("tt_01", 64'(y1), 64'h1);
    a1 = 1; b1 = 0; #10; chk("tt_10", 64'(y1), 64'h1);
    a1 = 1; b1 = 1; #10; chk("tt_11", 64'(y1), 64'h0);

    // Reset priority: a valid 11 sample with rst high is dropped
    v1 = 1;
    tick();
    chk("rp_y_reg", 64'(yr1),  64'h1);
    chk("rp_ov",    64'(ov1),  64'h0);
    chk("rp_cnt",   64'(cnt1), 64'h0);
    chk("rp_combo", 64'(cs1),  64'h0);
    chk("rp_y",     64'(y1),   64'h0);

    // Registered path: first accept on first edge with rst low
    rst = 1'b0;
    tick();
    chk("reg_y_reg", 64'(yr1),  64'h0);
    chk("reg_ov",    64'(ov1),  64'h1);
    chk("reg_cnt",   64'(cnt1), 64'h1);
    chk("reg_combo", 64'(cs1),  64'h8);
    v1 = 0;
    tick();
    chk("idle_ov",    64'(ov1), 64'h0);
    chk("idle_y_reg", 64'(yr1), 64'h0);
    chk("idle_cnt",   64'(cnt1), 64'h1);

    // Fresh reset, then coverage sequence 00, 01, 10, 11
    rst = 1'b1;
    tick();
    chk("rst2_combo", 64'(cs1), 64'h0);
    rst = 1'b0;
    v1 = 1; a1 = 0; b1 = 0;
    tick();
    chk("cov00_combo", 64'(cs1), 64'h1);
    chk("cov00_y_reg", 64'(yr1), 64'h1);
    a1 = 0; b1 = 1;
    tick();
    chk("cov01_combo", 64'(cs1), 64'h3);
    chk("cov01_ov",    64'(ov1), 64'h1);
    a1 = 1; b1 = 0;
    tick();
    chk("cov10_combo", 64'(cs1), 64'h7);
    chk("cov10_all",   64'(as1), 64'h0);
    chk("cov10_ov",    64'(ov1), 64'h1);
    a1 = 1; b1 = 1;
    tick();
    chk("cov11_combo", 64'(cs1),  64'hF);
    chk("cov11_all",   64'(as1),  64'h1);
    chk("cov11_cnt",   64'(cnt1), 64'h4);
    chk("cov11_y_reg", 64'(yr1),  64'h0);
    v1 = 0;
    tick();
    chk("cov_hold_combo", 64'(cs1), 64'hF);

    // Vector width
    a8 = 8'hF0; b8 = 8'hCC; v8 = 1;
    #1;
    chk("w8_y_comb", 64'(y8), 64'h3F);
    tick();
    chk("w8_y_reg",  64'(yr8), 64'h3F);
    chk("w8_ov",     64'(ov8), 64'h1);
    chk("w8_combo",  64'(cs8), 64'h1);
    a8 = 8'hFF; b8 = 8'h0F;
    #1;
    chk("w8_y_comb2", 64'(y8), 64'hF0);
    tick();
    chk("w8_y_reg2", 64'(yr8), 64'hF0);
    chk("w8_cnt",    64'(cnt8), 64'h2);
    v8 = 0;

    // Counter saturation, CNT_W=2
    ac = 1; bc = 0; vc = 1;
    tick(); chk("sat_1", 64'(cntc), 64'h1);
    tick(); chk("sat_2", 64'(cntc), 64'h2);
    tick(); chk("sat_3", 64'(cntc), 64'h3);
    tick(); chk("sat_4", 64'(cntc), 64'h3);
    tick(); chk("sat_5", 64'(cntc), 64'h3);
    vc = 0;
    tick();
    chk("sat_ov_drop", 64'(ovc), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nand_logic.md
# nand_logic

Bitwise two-input NAND primitive with a registered, handshaked output stage and sticky truth-table coverage flags. It sits at the bottom of the logic-primitive library as a reference combinational cell. It provides an immediate combinational result and a clock-aligned copy for downstream synchronous logic. The coverage flags let bring-up logic confirm that all four input combinations have been exercised.

## Interface
Parameters:
- WIDTH, 1, bit width of operands `a`, `b` and results; legal range 1..64.
- CNT_W, 16, width of the accepted-sample counter.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- in_valid  input  1  qualifies `a`/`b` for the registered path.
- y  output  WIDTH  combinational result, `~(a & b)` bitwise.
- y_reg  output  WIDTH  registered result of the last accepted sample.
- out_valid  output  1  high for exactly the cycle after an accepted sample.
- combo_seen  output  4  sticky flags; bit index = `{a[0], b[0]}` of accepted samples.
- all_seen  output  1  AND-reduction of `combo_seen`.
- sample_cnt  output  CNT_W  count of accepted samples, saturating.

## Operation
- `y` is purely combinational: `y[i] = ~(a[i] & b[i])` for every bit.
  - It is independent of `clk`, `rst` and `in_valid`.
  - Truth table per bit: 00→1, 01→1, 10→1, 11→0.
- Acceptance: a sample is accepted on a rising edge where `rst` = 0 and `in_valid` = 1.
- On acceptance:
  - `y_reg` ← `~(a & b)`.
  - `out_valid` ← 1.
  - `combo_seen[{a[0],b[0]}]` ← 1.
  - `sample_cnt` increments by 1; it saturates at all-ones and does not wrap.
- On a non-accepting edge:
  - `out_valid` ← 0.
  - `y_reg` holds its value.
  - `combo_seen` holds its value.
  - `sample_cnt` holds its value.
- `all_seen` is combinational from `combo_seen`.
- Reset (rst = 1 at a rising edge), which takes priority over `in_valid`:
  - `y_reg` ← all ones, the NAND of zero operands.
  - `out_valid` ← 0.
  - `combo_seen` ← 0.
  - `sample_cnt` ← 0.
- `y` is unaffected by reset.
- Reset mid-operation: any sample presented in the same cycle as `rst` is dropped. It is not counted and not flagged.
- X/Z on inputs is not handled specially; 2-state behaviour is required.

## Timing
- `y`: zero-cycle combinational latency.
- `y_reg` / `out_valid`: one-cycle latency.
  - Values appear after the rising edge that accepts the sample.
  - They are valid for sampling before the next edge.
- Back-to-back accepts are allowed every cycle. With `in_valid` held high, `out_valid` stays high continuously.
- No backpressure: the block always accepts.
- `combo_seen` and `sample_cnt` update on the same edge as `y_reg`.
- `all_seen` rises in the cycle after the fourth distinct combination is accepted.
- After reset deassertion, the first accept can occur on the first edge with `rst` = 0.

## Test plan
- Combinational truth table (WIDTH=1): apply a,b = 00, 01, 10, 11, holding each for 10 time units -> y = 1, 1, 1, 0 respectively.
- Registered path: after reset, present a=1,b=1 with in_valid=1 for one edge -> next cycle y_reg=0, out_valid=1; following idle cycle out_valid=0, y_reg=0 held.
- Coverage: accept 00, 01, 10 -> combo_seen=4'b0111, all_seen=0; then accept 11 -> combo_seen=4'b1111, all_seen=1, sample_cnt=4.
- Reset priority: assert rst with in_valid=1, a=b=1 -> next cycle y_reg=all ones, out_valid=0, sample_cnt=0, combo_seen=0; y stays 0 throughout.
- Vector width (WIDTH=8): a=8'hF0, b=8'hCC accepted -> y=8'h3F immediately; y_reg=8'h3F one cycle later.
- Counter saturation (CNT_W=2): accept 5 consecutive samples -> sample_cnt reads 1, 2, 3, 3, 3.
